// File: rtl/dma_pkg.sv
// Shared definitions for the MM2S DMA engine: completion codes, FSM states
// and the AXI 4 KiB burst boundary.
package dma_pkg;

    localparam logic [3:0] DMA_OK           = 4'h0;
    localparam logic [3:0] DMA_ERR_ZERO_LEN = 4'h1;
    localparam logic [3:0] DMA_ERR_RRESP    = 4'h2;

    localparam int unsigned DMA_4K_BYTES = 4096;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData,
        StStatus
    } dma_state_e;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream skid buffer: registered outputs, one-cycle latency,
// full throughput, upstream ready derived from free space.
module axis_skid_buffer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready,
    output logic             o_empty
);

    logic             r_valid;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_skid_data;

    assign o_ready = !r_skid_valid;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_empty = !r_valid && !r_skid_valid;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_valid      <= 1'b0;
            r_skid_valid <= 1'b0;
            r_data       <= '0;
            r_skid_data  <= '0;
        end else if (!r_skid_valid) begin
            if (!r_valid || i_ready) begin
                r_valid <= i_valid;
                r_data  <= i_data;
            end else if (i_valid) begin
                // Output stalled: park the incoming beat in the skid slot.
                r_skid_valid <= 1'b1;
                r_skid_data  <= i_data;
            end
        end else if (i_ready) begin
            r_data       <= r_skid_data;
            r_skid_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dma_mm2s_engine.sv
// Memory-mapped to AXI-Stream DMA read engine: one descriptor at a time, 4 KiB-safe bursts.
// Define DMA_MM2S_AXIS_SKID_EN to register the AXIS outputs through a skid buffer.
module dma_mm2s_engine #(
    parameter int unsigned AXI_ADDR_WIDTH  = 32,
    parameter int unsigned AXI_DATA_WIDTH  = 32,
    parameter int unsigned AXI_LEN_WIDTH   = 32,
    parameter int unsigned AXIS_USER_WIDTH = 65,
    parameter int unsigned MAX_BURST_LEN   = 16
) (
    input  logic                                    clk,
    input  logic                                    rstn,
    input  logic [AXI_ADDR_WIDTH+AXI_LEN_WIDTH-1:0] desc,
    input  logic [AXIS_USER_WIDTH-1:0]              user,
    input  logic                                    desc_valid,
    output logic                                    desc_ready,
    output logic [3:0]                              status_error,
    output logic                                    status_valid,
    output logic [AXI_ADDR_WIDTH-1:0]               m_axi_araddr,
    output logic [7:0]                              m_axi_arlen,
    output logic                                    m_axi_arvalid,
    input  logic                                    m_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0]               m_axi_rdata,
    input  logic [1:0]                              m_axi_rresp,
    input  logic                                    m_axi_rlast,
    input  logic                                    m_axi_rvalid,
    output logic                                    m_axi_rready,
    output logic [AXI_DATA_WIDTH-1:0]               m_axis_tdata,
    output logic [AXI_DATA_WIDTH/8-1:0]             m_axis_tkeep,
    output logic [AXIS_USER_WIDTH-1:0]              m_axis_tuser,
    output logic                                    m_axis_tlast,
    output logic                                    m_axis_tvalid,
    input  logic                                    m_axis_tready
);
    import dma_pkg::*;

    localparam int unsigned BYTES = AXI_DATA_WIDTH / 8;
    localparam int unsigned OFFS  = $clog2(BYTES);
    localparam int unsigned TW    = OFFS + 1;

    dma_state_e                 r_state, w_state_nxt;
    logic                       r_ready_en;
    logic [AXI_ADDR_WIDTH-1:0]  r_addr;
    logic [AXI_LEN_WIDTH-1:0]   r_beats_rem;
    logic [8:0]                 r_burst_rem;
    logic [TW-1:0]              r_tail;
    logic [AXIS_USER_WIDTH-1:0] r_user;
    logic [3:0]                 r_err;

    logic [AXI_ADDR_WIDTH-1:0]  w_desc_addr;
    logic [AXI_LEN_WIDTH-1:0]   w_desc_bytes;
    logic [TW-1:0]              w_tail;
    logic [AXI_LEN_WIDTH-1:0]   w_beats;
    logic [AXI_LEN_WIDTH-1:0]   w_beats_after;
    logic [12:0]                w_to_4k;
    logic [12:0]                w_burst;
    logic [BYTES-1:0]           w_keep_last;
    logic [BYTES-1:0]           w_tkeep;
    logic                       w_accept;
    logic                       w_rhs;
    logic                       w_in_beat;
    logic                       w_tlast;
    logic                       w_out_idle;
    logic                       w_unused_rlast;

    // Burst boundaries come from the local beat counter, so rlast is not needed.
    assign w_unused_rlast = m_axi_rlast;

    assign w_desc_addr  = desc[AXI_ADDR_WIDTH-1:0];
    assign w_desc_bytes = desc[AXI_ADDR_WIDTH +: AXI_LEN_WIDTH];
    assign w_tail       = TW'(w_desc_bytes & AXI_LEN_WIDTH'(BYTES - 1));
    assign w_beats      = (w_desc_bytes >> OFFS) + AXI_LEN_WIDTH'(w_tail != '0);

    assign w_accept      = desc_valid && desc_ready;
    assign w_rhs         = m_axi_rvalid && m_axi_rready;
    assign w_in_beat     = (r_state == StData) && (r_burst_rem != '0);
    assign w_beats_after = r_beats_rem - AXI_LEN_WIDTH'(w_rhs);
    assign w_to_4k       = (13'(DMA_4K_BYTES) - {1'b0, r_addr[11:0]}) >> OFFS;

    always_comb begin
        w_burst = w_to_4k;
        if (13'(MAX_BURST_LEN) < w_burst) w_burst = 13'(MAX_BURST_LEN);
        if (r_beats_rem < AXI_LEN_WIDTH'(w_burst)) w_burst = 13'(r_beats_rem);
    end

    always_comb begin
        w_keep_last = '0;
        for (int i = 0; i < BYTES; i++) begin
            w_keep_last[i] = (r_tail == '0) || (TW'(i) < r_tail);
        end
    end

    assign w_tlast = w_in_beat && (r_beats_rem == AXI_LEN_WIDTH'(1));
    assign w_tkeep = w_tlast ? w_keep_last : '1;

    assign desc_ready    = (r_state == StIdle) && r_ready_en;
    assign status_valid  = (r_state == StStatus);
    assign status_error  = (r_state == StStatus) ? r_err : '0;
    assign m_axi_arvalid = (r_state == StAddr);
    assign m_axi_araddr  = (r_state == StAddr) ? r_addr : '0;
    assign m_axi_arlen   = (r_state == StAddr) ? 8'(w_burst - 13'd1) : '0;

`ifdef DMA_MM2S_AXIS_SKID_EN
    localparam int unsigned PW = AXI_DATA_WIDTH + BYTES + AXIS_USER_WIDTH + 1;

    logic [PW-1:0] w_skid_in;
    logic [PW-1:0] w_skid_out;
    logic          w_skid_ready;
    logic          w_skid_empty;

    assign w_skid_in = {w_tlast, w_tkeep, r_user, m_axi_rdata};

    axis_skid_buffer #(
        .WIDTH(PW)
    ) u_skid (
        .i_clk  (clk),
        .i_rstn (rstn),
        .i_valid(w_in_beat && m_axi_rvalid),
        .i_data (w_skid_in),
        .o_ready(w_skid_ready),
        .o_valid(m_axis_tvalid),
        .o_data (w_skid_out),
        .i_ready(m_axis_tready),
        .o_empty(w_skid_empty)
    );

    assign {m_axis_tlast, m_axis_tkeep, m_axis_tuser, m_axis_tdata} = w_skid_out;
    assign m_axi_rready = w_in_beat && w_skid_ready;
    assign w_out_idle   = w_skid_empty;
`else
    assign m_axi_rready  = w_in_beat && m_axis_tready;
    assign m_axis_tvalid = w_in_beat && m_axi_rvalid;
    assign m_axis_tdata  = w_in_beat ? m_axi_rdata : '0;
    assign m_axis_tkeep  = w_in_beat ? w_tkeep : '0;
    assign m_axis_tuser  = w_in_beat ? r_user : '0;
    assign m_axis_tlast  = w_tlast;
    assign w_out_idle    = 1'b1;
`endif

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) w_state_nxt = (w_desc_bytes == '0) ? StStatus : StAddr;
            end
            StAddr: begin
                if (m_axi_arready) w_state_nxt = StData;
            end
            StData: begin
                // Burst finished: next burst, or wait for the output path to drain.
                if ((r_burst_rem == '0) || (w_rhs && (r_burst_rem == 9'd1))) begin
                    if (w_beats_after != '0) w_state_nxt = StAddr;
                    else if (w_out_idle)     w_state_nxt = StStatus;
                end
            end
            StStatus: w_state_nxt = StIdle;
            default:  w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= StIdle;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ready_en  <= 1'b0;
            r_addr      <= '0;
            r_beats_rem <= '0;
            r_burst_rem <= '0;
            r_tail      <= '0;
            r_user      <= '0;
            r_err       <= DMA_OK;
        end else begin
            r_ready_en <= 1'b1;
            if (w_accept) begin
                r_addr      <= w_desc_addr & ~AXI_ADDR_WIDTH'(BYTES - 1);
                r_beats_rem <= w_beats;
                r_burst_rem <= '0;
                r_tail      <= w_tail;
                r_user      <= user;
                r_err       <= (w_desc_bytes == '0) ? DMA_ERR_ZERO_LEN : DMA_OK;
            end
            if ((r_state == StAddr) && m_axi_arready) begin
                r_burst_rem <= 9'(w_burst);
                r_addr      <= r_addr + (AXI_ADDR_WIDTH'(w_burst) << OFFS);
            end
            if (w_rhs) begin
                r_beats_rem <= r_beats_rem - AXI_LEN_WIDTH'(1);
                r_burst_rem <= r_burst_rem - 9'd1;
                if (m_axi_rresp != 2'b00) r_err <= DMA_ERR_RRESP;
            end
        end
    end

endmodule

// File: tb/tb_dma_mm2s_engine.sv
// Directed self-checking bench for dma_mm2s_engine: a bench-side AXI read slave
// records AR requests and AXIS beats, and each scenario task checks them.
module tb_dma_mm2s_engine;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [63:0] desc = '0;
    logic [64:0] user = '0;
    logic        desc_valid = 1'b0;
    logic        desc_ready;
    logic [3:0]  status_error;
    logic        status_valid;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic [31:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = '0;
    logic        m_axi_rlast = 1'b0;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic [64:0] m_axis_tuser;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    // Recorded observations of the last transfer.
    int          n_ar, n_beats, n_status;
    logic [31:0] oa_addr[8];
    logic [7:0]  oa_len[8];
    logic [31:0] ob_data[64];
    logic [3:0]  ob_keep[64];
    logic        ob_last[64];
    logic [64:0] ob_user;
    logic [3:0]  st_err;
    logic        st_dready, post_dready;
    bit          rst_done;
    logic [7:0]  rst_outs;
    logic        rst_rel_dready, rst_after_dready;

    localparam logic [64:0] USER_A = {1'b1, 64'hDEAD_BEEF_0123_4567};
    localparam logic [64:0] USER_B = {1'b0, 64'h0F0F_1234_5678_9ABC};

    always #5 clk = ~clk;

    dma_mm2s_engine u_dut (
        .clk          (clk),
        .rstn         (rstn),
        .desc         (desc),
        .user         (user),
        .desc_valid   (desc_valid),
        .desc_ready   (desc_ready),
        .status_error (status_error),
        .status_valid (status_valid),
        .m_axi_araddr (m_axi_araddr),
        .m_axi_arlen  (m_axi_arlen),
        .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rdata  (m_axi_rdata),
        .m_axi_rresp  (m_axi_rresp),
        .m_axi_rlast  (m_axi_rlast),
        .m_axi_rvalid (m_axi_rvalid),
        .m_axi_rready (m_axi_rready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready)
    );

    // Issue one descriptor and act as the memory slave until status (or reset) settles.
    // Memory word at byte address A reads as A ^ 32'hA5A5_0000.
    task automatic run_xfer(input logic [31:0] a, input logic [31:0] b, input int err_beat,
                            input bit toggle, input int rst_beat);
        int          beat_left, beat_idx, stop_at;
        logic [31:0] cur;
        bit          ar_hs, r_hs, post_pending;
        n_ar = 0; n_beats = 0; n_status = 0; st_err = 4'hF;
        st_dready = 1'b1; post_dready = 1'b0; post_pending = 1'b0;
        rst_done = 1'b0; rst_outs = 8'hFF; rst_rel_dready = 1'b1; rst_after_dready = 1'b0;
        beat_left = 0; beat_idx = 0; cur = '0; stop_at = 400;
        @(negedge clk);
        desc = {b, a};
        desc_valid = 1'b1;
        for (int w = 0; w < 20 && !desc_ready; w++) @(negedge clk);
        @(posedge clk);
        #1;
        desc_valid = 1'b0;
        for (int c = 0; c < stop_at; c++) begin
            @(negedge clk);
            m_axi_arready = m_axi_arvalid && (beat_left == 0);
            m_axi_rvalid  = (beat_left > 0);
            m_axi_rdata   = cur ^ 32'hA5A5_0000;
            m_axi_rresp   = (beat_idx == err_beat) ? 2'b10 : 2'b00;
            m_axi_rlast   = (beat_left == 1);
            m_axis_tready = toggle ? (c % 2 == 1) : 1'b1;
            #1;
            if (rst_beat >= 0 && n_beats == rst_beat && !rst_done) begin
                rst_done = 1'b1;
                rstn = 1'b0;
                #1;
                rst_outs = {desc_ready, m_axi_arvalid, m_axi_rready, m_axis_tvalid,
                            m_axis_tlast, status_valid, |status_error, |m_axis_tdata};
                m_axi_rvalid = 1'b0;
                m_axi_arready = 1'b0;
                beat_left = 0;
                @(posedge clk);
                @(negedge clk);
                rstn = 1'b1;
                #1;
                rst_rel_dready = desc_ready;
                @(posedge clk);
                #1;
                rst_after_dready = desc_ready;
                stop_at = c + 12;
                continue;
            end
            if (post_pending) begin
                post_dready = desc_ready;
                post_pending = 1'b0;
            end
            if (status_valid) begin
                n_status++;
                st_err = status_error;
                st_dready = desc_ready;
                post_pending = 1'b1;
                if (stop_at > c + 4) stop_at = c + 4;
            end
            if (m_axis_tvalid && m_axis_tready && n_beats < 64) begin
                ob_data[n_beats] = m_axis_tdata;
                ob_keep[n_beats] = m_axis_tkeep;
                ob_last[n_beats] = m_axis_tlast;
                if (n_beats == 0) ob_user = m_axis_tuser;
                n_beats++;
            end
            ar_hs = m_axi_arvalid && m_axi_arready;
            r_hs  = m_axi_rvalid && m_axi_rready;
            if (ar_hs && n_ar < 8) begin
                oa_addr[n_ar] = m_axi_araddr;
                oa_len[n_ar]  = m_axi_arlen;
                n_ar++;
            end
            if (ar_hs) begin
                beat_left = int'(m_axi_arlen) + 1;
                cur = m_axi_araddr;
            end
            if (r_hs) begin
                beat_left--;
                cur += 32'd4;
                beat_idx++;
            end
        end
        @(negedge clk);
        m_axi_rvalid = 1'b0;
        m_axi_arready = 1'b0;
        m_axis_tready = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({desc_ready, m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_rready, m_axis_tvalid,
             m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast, status_valid,
             status_error} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got dr=%b arv=%b rr=%b tv=%b sv=%b, required all zero",
                     desc_ready, m_axi_arvalid, m_axi_rready, m_axis_tvalid, status_valid);
        end
        rstn = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (desc_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_ready_after: got %b required 1", desc_ready);
        end
    endtask

    task automatic test_single_burst();
        user = USER_A;
        run_xfer(32'h0000_1000, 32'd64, -1, 1'b0, -1);
        n_checks++;
        if ({n_ar, oa_addr[0], oa_len[0]} !== {32'd1, 32'h0000_1000, 8'd15}) begin
            n_errors++;
            $display("FAIL single_ar: got n=%0d addr=%h len=%0d required 1 00001000 15",
                     n_ar, oa_addr[0], oa_len[0]);
        end
        n_checks++;
        if (n_beats !== 16) begin
            n_errors++;
            $display("FAIL single_beats: got %0d required 16", n_beats);
        end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if ({ob_data[i], ob_keep[i], ob_last[i]} !==
                {(32'h1000 + 32'(4 * i)) ^ 32'hA5A5_0000, 4'hF, (i == 15)}) begin
                n_errors++;
                $display("FAIL single_beat%0d: got %h/%h/%b", i, ob_data[i], ob_keep[i], ob_last[i]);
            end
        end
        n_checks++;
        if (ob_user !== USER_A) begin
            n_errors++;
            $display("FAIL single_tuser: got %h required %h", ob_user, USER_A);
        end
        n_checks++;
        if ({n_status, st_err} !== {32'd1, 4'h0}) begin
            n_errors++;
            $display("FAIL single_status: got n=%0d err=%h required 1 0", n_status, st_err);
        end
    endtask

    task automatic test_4k_split();
        user = USER_B;
        run_xfer(32'h0000_0FF8, 32'd32, -1, 1'b1, -1);
        n_checks++;
        if ({n_ar, oa_addr[0], oa_len[0], oa_addr[1], oa_len[1]} !==
            {32'd2, 32'h0000_0FF8, 8'd1, 32'h0000_1000, 8'd5}) begin
            n_errors++;
            $display("FAIL split_ar: got n=%0d %h/%0d %h/%0d required 2 00000ff8/1 00001000/5",
                     n_ar, oa_addr[0], oa_len[0], oa_addr[1], oa_len[1]);
        end
        n_checks++;
        if (n_beats !== 8) begin
            n_errors++;
            $display("FAIL split_beats: got %0d required 8", n_beats);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if ({ob_data[i], ob_keep[i], ob_last[i]} !==
                {(32'h0FF8 + 32'(4 * i)) ^ 32'hA5A5_0000, 4'hF, (i == 7)}) begin
                n_errors++;
                $display("FAIL split_beat%0d: got %h/%h/%b", i, ob_data[i], ob_keep[i], ob_last[i]);
            end
        end
        n_checks++;
        if ({n_status, st_err} !== {32'd1, 4'h0}) begin
            n_errors++;
            $display("FAIL split_status: got n=%0d err=%h required 1 0", n_status, st_err);
        end
    endtask

    task automatic test_partial();
        run_xfer(32'h0000_2003, 32'd10, -1, 1'b0, -1);
        n_checks++;
        if ({n_ar, oa_addr[0], oa_len[0]} !== {32'd1, 32'h0000_2000, 8'd2}) begin
            n_errors++;
            $display("FAIL partial_ar: got n=%0d addr=%h len=%0d required 1 00002000 2",
                     n_ar, oa_addr[0], oa_len[0]);
        end
        n_checks++;
        if (n_beats !== 3) begin
            n_errors++;
            $display("FAIL partial_beats: got %0d required 3", n_beats);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({ob_data[i], ob_keep[i], ob_last[i]} !==
                {(32'h2000 + 32'(4 * i)) ^ 32'hA5A5_0000, (i == 2) ? 4'b0011 : 4'hF, (i == 2)}) begin
                n_errors++;
                $display("FAIL partial_beat%0d: got %h/%h/%b", i, ob_data[i], ob_keep[i], ob_last[i]);
            end
        end
    endtask

    task automatic test_max_burst();
        run_xfer(32'h0000_3000, 32'd128, -1, 1'b0, -1);
        n_checks++;
        if ({n_ar, oa_addr[0], oa_len[0], oa_addr[1], oa_len[1]} !==
            {32'd2, 32'h0000_3000, 8'd15, 32'h0000_3040, 8'd15}) begin
            n_errors++;
            $display("FAIL maxb_ar: got n=%0d %h/%0d %h/%0d required 2 00003000/15 00003040/15",
                     n_ar, oa_addr[0], oa_len[0], oa_addr[1], oa_len[1]);
        end
        n_checks++;
        if ({n_beats, ob_last[15], ob_last[31], ob_data[31]} !==
            {32'd32, 1'b0, 1'b1, 32'h307C ^ 32'hA5A5_0000}) begin
            n_errors++;
            $display("FAIL maxb_beats: got n=%0d last15=%b last31=%b d31=%h", n_beats,
                     ob_last[15], ob_last[31], ob_data[31]);
        end
    endtask

    task automatic test_zero_len();
        run_xfer(32'h0000_8000, 32'd0, -1, 1'b0, -1);
        n_checks++;
        if ({n_ar, n_beats} !== {32'd0, 32'd0}) begin
            n_errors++;
            $display("FAIL zero_no_traffic: got ar=%0d beats=%0d required 0 0", n_ar, n_beats);
        end
        n_checks++;
        if ({n_status, st_err} !== {32'd1, 4'h1}) begin
            n_errors++;
            $display("FAIL zero_status: got n=%0d err=%h required 1 1", n_status, st_err);
        end
    endtask

    task automatic test_rresp_err();
        run_xfer(32'h0000_4000, 32'd16, 1, 1'b0, -1);
        n_checks++;
        if (n_beats !== 4) begin
            n_errors++;
            $display("FAIL rresp_beats: got %0d required 4", n_beats);
        end
        n_checks++;
        if ({ob_data[3], ob_last[3]} !== {32'h400C ^ 32'hA5A5_0000, 1'b1}) begin
            n_errors++;
            $display("FAIL rresp_last_beat: got %h/%b", ob_data[3], ob_last[3]);
        end
        n_checks++;
        if ({n_status, st_err} !== {32'd1, 4'h2}) begin
            n_errors++;
            $display("FAIL rresp_status: got n=%0d err=%h required 1 2", n_status, st_err);
        end
    endtask

    task automatic test_back_to_back();
        run_xfer(32'h0000_6000, 32'd8, -1, 1'b0, -1);
        n_checks++;
        if ({st_err, st_dready, post_dready} !== {4'h0, 1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL b2b_first: got err=%h ready_at_status=%b ready_after=%b required 0 0 1",
                     st_err, st_dready, post_dready);
        end
        run_xfer(32'h0000_6100, 32'd4, -1, 1'b0, -1);
        n_checks++;
        if ({n_beats, ob_data[0], ob_keep[0], ob_last[0], n_status, st_err} !==
            {32'd1, 32'h6100 ^ 32'hA5A5_0000, 4'hF, 1'b1, 32'd1, 4'h0}) begin
            n_errors++;
            $display("FAIL b2b_second: got beats=%0d d=%h k=%h l=%b st=%0d err=%h",
                     n_beats, ob_data[0], ob_keep[0], ob_last[0], n_status, st_err);
        end
    endtask

    task automatic test_reset_mid();
        run_xfer(32'h0000_5000, 32'd64, -1, 1'b1, 5);
        n_checks++;
        if ({rst_done, n_beats} !== {1'b1, 32'd5}) begin
            n_errors++;
            $display("FAIL rstmid_beats: got done=%b beats=%0d required 1 5", rst_done, n_beats);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (ob_data[i] !== ((32'h5000 + 32'(4 * i)) ^ 32'hA5A5_0000)) begin
                n_errors++;
                $display("FAIL rstmid_beat%0d: got %h", i, ob_data[i]);
            end
        end
        n_checks++;
        if ({rst_outs, rst_rel_dready, rst_after_dready} !== {8'h00, 1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL rstmid_outputs: got outs=%h rel=%b after=%b required 00 0 1",
                     rst_outs, rst_rel_dready, rst_after_dready);
        end
        n_checks++;
        if (n_status !== 0) begin
            n_errors++;
            $display("FAIL rstmid_no_status: got %0d required 0", n_status);
        end
        run_xfer(32'h0000_7000, 32'd12, -1, 1'b0, -1);
        n_checks++;
        if ({n_ar, oa_len[0], n_beats, ob_data[0], ob_last[2], n_status, st_err} !==
            {32'd1, 8'd2, 32'd3, 32'h7000 ^ 32'hA5A5_0000, 1'b1, 32'd1, 4'h0}) begin
            n_errors++;
            $display("FAIL rstmid_recover: got ar=%0d len=%0d beats=%0d d0=%h st=%0d err=%h",
                     n_ar, oa_len[0], n_beats, ob_data[0], n_status, st_err);
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_4k_split();
        test_partial();
        test_max_burst();
        test_zero_len();
        test_rresp_err();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dma_mm2s_engine.md
DMA_MM2S_ENGINE -- requirements
Module: dma_mm2s_engine

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 32, meaning byte-address width of the descriptor and AR channel.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 32, meaning R/AXIS data width in bits (BYTES = AXI_DATA_WIDTH/8).
REQ-003 SHALL have parameter AXI_LEN_WIDTH, default 32, meaning descriptor byte-count width.
REQ-004 SHALL have parameter AXIS_USER_WIDTH, default 65, meaning tuser width.
REQ-005 SHALL have parameter MAX_BURST_LEN, default 16, meaning maximum beats per AR burst (1..256).
REQ-006 SHALL have ports: clk  in  1  clock; rstn  in  1  reset. One clock; reset is asynchronous and active-low.
REQ-007 SHALL have ports: desc  in  AXI_ADDR_WIDTH+AXI_LEN_WIDTH  {bytes, addr}; user  in  AXIS_USER_WIDTH  tuser for the transfer; desc_valid  in  1; desc_ready  out  1.
REQ-008 SHALL have ports: status_error  out  4  completion code; status_valid  out  1  completion pulse.
REQ-009 SHALL have ports: m_axi_araddr  out  AXI_ADDR_WIDTH; m_axi_arlen  out  8; m_axi_arvalid  out  1; m_axi_arready  in  1.
REQ-010 SHALL have ports: m_axi_rdata  in  AXI_DATA_WIDTH; m_axi_rresp  in  2; m_axi_rlast  in  1; m_axi_rvalid  in  1; m_axi_rready  out  1.
REQ-011 SHALL have ports: m_axis_tdata  out  AXI_DATA_WIDTH; m_axis_tkeep  out  BYTES; m_axis_tuser  out  AXIS_USER_WIDTH; m_axis_tlast  out  1; m_axis_tvalid  out  1; m_axis_tready  in  1.

Function
REQ-012 SHALL implement FSM IDLE -> ADDR -> DATA -> (ADDR if beats remain, else STATUS) -> IDLE.
REQ-013 SHALL assert desc_ready only in IDLE; on desc_valid&&desc_ready SHALL latch addr (low log2(BYTES) bits forced 0), bytes and user.
REQ-014 SHALL compute total beats = ceil(bytes/BYTES); bytes==0 SHALL go directly to STATUS with status_error=4'h1, no AR issued.
REQ-015 SHALL size each burst = min(remaining beats, MAX_BURST_LEN, beats to next 4 KiB boundary); arlen = burst-1.
REQ-016 SHALL hold araddr/arlen stable with arvalid high in ADDR until arready; exactly one burst outstanding.
REQ-017 In DATA SHALL pass R to AXIS combinationally: tvalid=rvalid, rready=tready, tdata=rdata, tuser=latched user.
REQ-018 SHALL set tlast only on the final beat of the whole transfer; burst-internal rlast SHALL NOT drive tlast.
REQ-019 SHALL set tkeep all-ones except final beat, where the low (bytes mod BYTES) lanes are set (all-ones if 0).
REQ-020 Any rresp!=0 SHALL sticky-latch error 4'h2; transfer SHALL still drain all beats.
REQ-021 STATUS SHALL pulse status_valid for exactly 1 cycle with status_error (4'h0 on success), then return to IDLE.
REQ-022 A new descriptor SHALL be accepted no earlier than the cycle after status_valid.

Reset
REQ-023 On rstn low all outputs SHALL be 0 (desc_ready 0 during reset, 1 the first cycle after) and FSM SHALL be IDLE.
REQ-024 Reset mid-transfer SHALL abandon it without status_valid; counters and latched error SHALL clear.

Configuration
REQ-025 Macro DMA_MM2S_AXIS_SKID_EN defined: AXIS outputs SHALL be driven by a 2-entry skid buffer (1-cycle latency, full throughput, rready from buffer space).
REQ-026 Macro undefined: REQ-017 combinational pass-through SHALL apply, zero latency.

Structure
REQ-027 Package dma_pkg SHALL hold status codes (DMA_OK=0, DMA_ERR_ZERO_LEN=1, DMA_ERR_RRESP=2), the FSM state enum and the 4 KiB constant.
REQ-028 Skid buffer SHALL be sub-module axis_skid_buffer, instantiated only under DMA_MM2S_AXIS_SKID_EN.

Verification
REQ-029 addr=0x1000, bytes=64, BYTES=4 -> one AR arlen=15, 16 beats, tlast on beat 16, tkeep=4'hF, status 0.
REQ-030 addr=0x0FF8, bytes=32 -> ARs (0x0FF8, arlen=1) then (0x1000, arlen=5); 8 beats total.
REQ-031 bytes=10 -> 3 beats, last tkeep=4'b0011, tlast on beat 3.
REQ-032 bytes=0 -> no arvalid, status_valid 1 cycle with status_error=1.
REQ-033 rresp=2'b10 on beat 2 of 4 -> all 4 beats delivered, status_error=2.
REQ-034 tready toggling 50% plus rstn pulse mid-burst -> no beat lost/duplicated before reset; idle, no status after.
